// File: rtl/avm_burst_pkg.sv
// Shared types, widths and address helper for the Avalon-MM burst memory responder.
package avm_burst_pkg;

    localparam int unsigned BURST_W = 12;
    localparam int unsigned DATA_W  = 32;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_STALL,
        RD_LAT,
        RD_DATA
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_STALL,
        WR_DATA
    } wr_state_t;

    // Byte address to word index; callers truncate to the memory address width.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage

// File: rtl/burst_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, read-before-write.
module burst_dp_ram
    import avm_burst_pkg::*;
#(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned WORD_W = DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    // Storage is never reset so written contents survive a mid-burst reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/avm_burst_mem_responder.sv
// Avalon-MM burst responder: independent read and write burst ports over one
// word-addressed memory, with wait states, read latency and sticky error flag.
module avm_burst_mem_responder
    import avm_burst_pkg::*;
#(
    parameter int unsigned MEM_ADDR_WIDTH = 12,
    parameter int unsigned RD_LATENCY     = 2,
    parameter int unsigned RD_WAIT_STATES = 1,
    parameter int unsigned WR_WAIT_STATES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        avs_rx_address,
    input  logic [BURST_W-1:0] avs_rx_burstcount,
    input  logic               avs_rx_read,
    output logic               avs_rx_waitrequest,
    output logic [DATA_W-1:0]  avs_rx_readdata,
    output logic               avs_rx_readdatavalid,
    input  logic [31:0]        avs_tx_address,
    input  logic [BURST_W-1:0] avs_tx_burstcount,
    input  logic               avs_tx_write,
    input  logic [DATA_W-1:0]  avs_tx_writedata,
    output logic               avs_tx_waitrequest,
    output logic               rd_busy,
    output logic               wr_busy,
    output logic               burst_err
);

    localparam int unsigned BEAT_W  = BURST_W + 1;
    localparam int unsigned STALL_W = 8;
    localparam int unsigned LAT_W   = 4;
    localparam int unsigned AW      = MEM_ADDR_WIDTH;

    localparam logic [STALL_W-1:0] RD_STALL_INIT = STALL_W'(RD_WAIT_STATES);
    // The idle cycle that first sees the write already shows waitrequest, so it counts as a stall.
    localparam logic [STALL_W-1:0] WR_STALL_INIT =
        (WR_WAIT_STATES == 0) ? '0 : STALL_W'(WR_WAIT_STATES - 1);
    localparam logic [LAT_W-1:0]   LAT_INIT = (RD_LATENCY <= 1) ? '0 : LAT_W'(RD_LATENCY - 1);
    localparam bit                 LAT_SKIP = (RD_LATENCY <= 1);

    rd_state_t          rd_state, rd_state_nx;
    logic [STALL_W-1:0] rd_stall, rd_stall_nx;
    logic [LAT_W-1:0]   rd_lat, rd_lat_nx;
    logic [BEAT_W-1:0]  rd_left, rd_left_nx;
    logic [AW-1:0]      rd_addr, rd_addr_nx;
    logic               rd_issue, rd_accept, rd_err_set;

    wr_state_t          wr_state, wr_state_nx;
    logic [STALL_W-1:0] wr_stall, wr_stall_nx;
    logic [BEAT_W-1:0]  wr_left, wr_left_nx;
    logic [AW-1:0]      wr_addr, wr_addr_nx;
    logic [AW-1:0]      wr_waddr, wr_first_addr;
    logic               wr_we, wr_accept, wr_err_set;

    assign rd_accept     = avs_rx_read && !avs_rx_waitrequest;
    assign wr_accept     = avs_tx_write && !avs_tx_waitrequest;
    assign wr_first_addr = AW'(word_index(avs_tx_address));

    // Read command, latency and beat sequencing.
    always_comb begin
        rd_state_nx = rd_state;
        rd_stall_nx = rd_stall;
        rd_lat_nx   = rd_lat;
        rd_left_nx  = rd_left;
        rd_addr_nx  = rd_addr;
        rd_issue    = 1'b0;
        rd_err_set  = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                if (avs_rx_read) begin
                    rd_state_nx = RD_STALL;
                    rd_stall_nx = RD_STALL_INIT;
                end
            end
            RD_STALL: begin
                if (rd_accept) begin
                    rd_addr_nx = AW'(word_index(avs_rx_address));
                    rd_left_nx = BEAT_W'(avs_rx_burstcount);
                    rd_lat_nx  = LAT_INIT;
                    if (avs_rx_burstcount == '0) begin
                        rd_err_set  = 1'b1;
                        rd_state_nx = RD_IDLE;
                    end else if (LAT_SKIP) begin
                        rd_state_nx = RD_DATA;
                    end else begin
                        rd_state_nx = RD_LAT;
                    end
                end else if (rd_stall != '0) begin
                    rd_stall_nx = rd_stall - STALL_W'(1);
                end
            end
            RD_LAT: begin
                if (rd_lat <= LAT_W'(1)) begin
                    rd_state_nx = RD_DATA;
                end else begin
                    rd_lat_nx = rd_lat - LAT_W'(1);
                end
            end
            RD_DATA: begin
                rd_issue   = 1'b1;
                rd_addr_nx = rd_addr + AW'(1);
                rd_left_nx = rd_left - BEAT_W'(1);
                if (rd_left == BEAT_W'(1)) begin
                    rd_state_nx = RD_IDLE;
                end
            end
            default: rd_state_nx = RD_IDLE;
        endcase
    end

    // Write stall and beat sequencing.
    always_comb begin
        wr_state_nx = wr_state;
        wr_stall_nx = wr_stall;
        wr_left_nx  = wr_left;
        wr_addr_nx  = wr_addr;
        wr_waddr    = wr_addr;
        wr_we       = 1'b0;
        wr_err_set  = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                if (avs_tx_write) begin
                    wr_state_nx = WR_STALL;
                    wr_stall_nx = WR_STALL_INIT;
                end
            end
            WR_STALL: begin
                if (wr_accept) begin
                    if (avs_tx_burstcount == '0) begin
                        wr_err_set  = 1'b1;
                        wr_state_nx = WR_IDLE;
                    end else begin
                        wr_we       = 1'b1;
                        wr_waddr    = wr_first_addr;
                        wr_addr_nx  = wr_first_addr + AW'(1);
                        wr_left_nx  = BEAT_W'(avs_tx_burstcount) - BEAT_W'(1);
                        wr_state_nx = (avs_tx_burstcount == BURST_W'(1)) ? WR_IDLE : WR_DATA;
                    end
                end else if (wr_stall != '0) begin
                    wr_stall_nx = wr_stall - STALL_W'(1);
                end
            end
            WR_DATA: begin
                if (wr_accept) begin
                    wr_we      = 1'b1;
                    wr_addr_nx = wr_addr + AW'(1);
                    wr_left_nx = wr_left - BEAT_W'(1);
                    if (wr_left == BEAT_W'(1)) begin
                        wr_state_nx = WR_IDLE;
                    end
                end
            end
            default: wr_state_nx = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state             <= RD_IDLE;
            rd_stall             <= '0;
            rd_lat               <= '0;
            rd_left              <= '0;
            rd_addr              <= '0;
            wr_state             <= WR_IDLE;
            wr_stall             <= '0;
            wr_left              <= '0;
            wr_addr              <= '0;
            avs_rx_waitrequest   <= 1'b1;
            avs_tx_waitrequest   <= 1'b1;
            avs_rx_readdatavalid <= 1'b0;
            rd_busy              <= 1'b0;
            wr_busy              <= 1'b0;
            burst_err            <= 1'b0;
        end else begin
            rd_state             <= rd_state_nx;
            rd_stall             <= rd_stall_nx;
            rd_lat               <= rd_lat_nx;
            rd_left              <= rd_left_nx;
            rd_addr              <= rd_addr_nx;
            wr_state             <= wr_state_nx;
            wr_stall             <= wr_stall_nx;
            wr_left              <= wr_left_nx;
            wr_addr              <= wr_addr_nx;
            avs_rx_waitrequest   <= !(rd_state_nx == RD_STALL && rd_stall_nx == '0);
            avs_tx_waitrequest   <= !((wr_state_nx == WR_STALL && wr_stall_nx == '0)
                                      || wr_state_nx == WR_DATA);
            avs_rx_readdatavalid <= rd_issue;
            // Busy stays up through the final data beat.
            rd_busy              <= rd_issue || rd_state_nx == RD_LAT || rd_state_nx == RD_DATA;
            wr_busy              <= wr_state_nx == WR_DATA;
            burst_err            <= burst_err | rd_err_set | wr_err_set;
        end
    end

    burst_dp_ram #(
        .ADDR_W (AW),
        .WORD_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_we),
        .waddr (wr_waddr),
        .wdata (avs_tx_writedata),
        .re    (rd_issue),
        .raddr (rd_addr),
        .rdata (avs_rx_readdata)
    );

endmodule
